complete_arbiter: RTL and testbench
===================================

# complete_arbiter

Buffered, parametrised complete/writeback stage for the R10K OoO core. Accepts results from NUM_SRC producers (ALU/mult/branch FUs and LSQ load ports) through per-source valid/ready FIFOs, selects up to CDB_WIDTH results per cycle with a rotating-priority arbiter, and drives registered PRF write, ROB complete and CDB broadcast lanes. It sits between the execute/LSQ stages and the PRF/ROB/RS wakeup logic. It replaces the single-cycle combinational merge, removes the silent-drop case when more results arrive than lanes, and adds flush and stall accounting.

## Interface
Parameters:
- XLEN, 32, data width
- PHYS_REGS, 128, physical register count; tag width PRF_W = $clog2(PHYS_REGS)
- ROB_DEPTH, 64, ROB entries; index width ROB_W = $clog2(ROB_DEPTH)
- NUM_SRC, 6, producer channels; FUs first, LSQ ports last
- CDB_WIDTH, 4, output lanes per cycle, 1 ≤ CDB_WIDTH ≤ NUM_SRC
- FIFO_DEPTH, 2, entries per source FIFO, ≥ 1

Ports:
- clock  in  1  system clock; one clock domain
- reset  in  1  synchronous, active-high
- flush_i  in  1  mispredict recovery; drops all buffered and in-flight results
- src_valid_i  in  NUM_SRC  result offered
- src_ready_o  out  NUM_SRC  source FIFO can accept
- src_value_i  in  NUM_SRC×XLEN  result value
- src_dest_prf_i  in  NUM_SRC×PRF_W  destination physical tag
- src_rob_idx_i  in  NUM_SRC×ROB_W  ROB index
- src_exception_i, src_mispred_i  in  NUM_SRC each  status bits
- prf_wr_en_o, prf_waddr_o, prf_wdata_o  out  CDB_WIDTH (×PRF_W / ×XLEN)  PRF write lanes
- wb_valid_o, wb_rob_idx_o, wb_exception_o, wb_mispred_o, wb_value_o  out  CDB_WIDTH lanes  ROB complete
- cdb_o  out  CDB_WIDTH×cdb_entry_t  wakeup broadcast
- stall_cycles_o  out  32  saturating count of cycles with any src_valid_i & ~src_ready_o

## Operation
- Enqueue: source s pushes when src_valid_i[s] & src_ready_o[s]. src_ready_o[s] = (count[s] < FIFO_DEPTH), a function of registered state only; it does not consider a same-cycle pop.
- Arbitration (combinational on FIFO heads): scan sources starting at rr_ptr, ascending modulo NUM_SRC; the k-th non-empty head found takes lane k, for k < CDB_WIDTH. Granted heads pop at the clock edge.
- rr_ptr update: becomes (last granted source + 1) mod NUM_SRC; unchanged if nothing is granted. Every non-empty source is granted within ceil(NUM_SRC/CDB_WIDTH) cycles.
- Output registers: lane k loads the granted entry. Unfilled lanes get valid = 0 and all fields 0. Lanes are packed from lane 0.
- Lane contents: all three output groups mirror the same entry.
  - prf_wr_en_o = wb_valid_o = cdb_o.valid
  - cdb_o.phys_tag = prf_waddr_o = dest_prf
  - cdb_o.value = prf_wdata_o = wb_value_o = value
  - cdb_o.dest_arch = 0
- Flush: at an edge with flush_i = 1:
  - all FIFO counts and pointers reset and output valid bits clear;
  - pushes in that cycle are dropped and no pop is taken;
  - rr_ptr is held;
  - stall_cycles_o still updates.
- Reset: FIFOs empty, rr_ptr = 0, every output 0, stall_cycles_o = 0, src_ready_o all 1 in the cycle after reset.
- Reset mid-operation: the same reset clears all in-flight state; reset has priority over flush.
- stall_cycles_o saturates at 32'hFFFF_FFFF.

## Timing
- Latency: a result accepted at edge E appears on the outputs after edge E+1 at the earliest, in the following cycle. There is no input-to-output bypass.
- Throughput: CDB_WIDTH results per cycle; each source sustains one per cycle when FIFO_DEPTH ≥ 2 and it wins arbitration every cycle.
- Full FIFO: ready goes low the cycle after the filling push. A source must hold valid and data stable until ready.
- Simultaneous push and pop on a full FIFO is not allowed, because ready is 0.
- Empty FIFO: a push and the first pop cannot happen in the same cycle.
- Per-source FIFO order is preserved. No ordering is guaranteed across sources.

## Structure
- cdb_entry_t is the existing type in def.svh. Add wb_entry_t {value, dest_prf, rob_idx, exception, mispred} there as well.
- Sub-module wb_fifo: a parametrised synchronous FIFO with push, pop, flush, count, full, empty and head outputs. It is instantiated NUM_SRC times.
- Arbiter and output registers live in complete_arbiter.

## Test plan
- Reset, then idle: all outputs 0, src_ready_o = 6'b111111, stall_cycles_o = 0.
- Single result: src 2 at edge E with value 32'hDEAD_BEEF, prf 17, rob 5 → lane 0 valid after E+1 carrying those values; lanes 1–3 invalid.
- Oversubscription: all 6 sources valid for 1 cycle, rr_ptr = 0 → cycle 1 lanes = src 0,1,2,3; cycle 2 lanes = src 4,5 with lanes 2–3 invalid; rr_ptr ends at 0; no result is lost.
- Backpressure: src 0 valid for 4 consecutive cycles while src 1–5 are continuously valid, FIFO_DEPTH = 2 → src_ready_o[0] drops, stall_cycles_o increments once per stalled cycle, and all src 0 values exit in order.
- Flush: 3 entries buffered plus valid outputs, flush_i for 1 cycle → next cycle all outputs invalid, FIFOs empty, rr_ptr unchanged, and a push in the flush cycle does not appear.
- Reset asserted while FIFOs are full → everything clears. A push in the first post-reset cycle emerges after the next edge.

Source files
------------

// File: rtl/complete_arbiter_pkg.sv
// Shared types for the complete/writeback stage: the CDB broadcast entry and
// the per-result record carried through the source FIFOs.
package complete_arbiter_pkg;

  localparam int unsigned CA_XLEN      = 32;
  localparam int unsigned CA_PHYS_REGS = 128;
  localparam int unsigned CA_ROB_DEPTH = 64;
  localparam int unsigned CA_PRF_W     = $clog2(CA_PHYS_REGS);
  localparam int unsigned CA_ROB_W     = $clog2(CA_ROB_DEPTH);
  localparam int unsigned CA_ARCH_W    = 5;

  // Wakeup broadcast lane.
  typedef struct packed {
    logic                 valid;
    logic [CA_PRF_W-1:0]  phys_tag;
    logic [CA_ARCH_W-1:0] dest_arch;
    logic [CA_XLEN-1:0]   value;
  } cdb_entry_t;

  // One completed result as buffered per source.
  typedef struct packed {
    logic [CA_XLEN-1:0]  value;
    logic [CA_PRF_W-1:0] dest_prf;
    logic [CA_ROB_W-1:0] rob_idx;
    logic                exception;
    logic                mispred;
  } wb_entry_t;

endpackage

// File: rtl/complete_arbiter_fifo.sv
// Small synchronous FIFO buffering results from one producer.
// Reset and flush both empty it; push when full and pop when empty are ignored.
module wb_fifo #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];
  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk_i) begin
    if (!rst_i && do_push) begin
      mem_q[wr_q] <= data_i;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= ptr_inc(wr_q);
      if (do_pop)  rd_q <= ptr_inc(rd_q);
      cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/complete_arbiter.sv
// Complete/writeback stage: per-source result FIFOs, rotating-priority
// selection of up to CDB_WIDTH heads per cycle, registered PRF/ROB/CDB lanes
// and a saturating backpressure cycle counter.
module complete_arbiter
  import complete_arbiter_pkg::*;
#(
  parameter  int unsigned XLEN       = CA_XLEN,
  parameter  int unsigned PHYS_REGS  = CA_PHYS_REGS,
  parameter  int unsigned ROB_DEPTH  = CA_ROB_DEPTH,
  parameter  int unsigned NUM_SRC    = 6,
  parameter  int unsigned CDB_WIDTH  = 4,
  parameter  int unsigned FIFO_DEPTH = 2,
  localparam int unsigned PRF_W      = $clog2(PHYS_REGS),
  localparam int unsigned ROB_W      = $clog2(ROB_DEPTH)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush_i,
  input  logic [NUM_SRC-1:0]           src_valid_i,
  output logic [NUM_SRC-1:0]           src_ready_o,
  input  logic [NUM_SRC*XLEN-1:0]      src_value_i,
  input  logic [NUM_SRC*PRF_W-1:0]     src_dest_prf_i,
  input  logic [NUM_SRC*ROB_W-1:0]     src_rob_idx_i,
  input  logic [NUM_SRC-1:0]           src_exception_i,
  input  logic [NUM_SRC-1:0]           src_mispred_i,
  output logic [CDB_WIDTH-1:0]         prf_wr_en_o,
  output logic [CDB_WIDTH*PRF_W-1:0]   prf_waddr_o,
  output logic [CDB_WIDTH*XLEN-1:0]    prf_wdata_o,
  output logic [CDB_WIDTH-1:0]         wb_valid_o,
  output logic [CDB_WIDTH*ROB_W-1:0]   wb_rob_idx_o,
  output logic [CDB_WIDTH-1:0]         wb_exception_o,
  output logic [CDB_WIDTH-1:0]         wb_mispred_o,
  output logic [CDB_WIDTH*XLEN-1:0]    wb_value_o,
  output cdb_entry_t [CDB_WIDTH-1:0]   cdb_o,
  output logic [31:0]                  stall_cycles_o
);

  localparam int unsigned SRC_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned LANE_W = (CDB_WIDTH > 1) ? $clog2(CDB_WIDTH) : 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

  wb_entry_t            head [NUM_SRC];
  logic [CNT_W-1:0]     fifo_cnt [NUM_SRC];
  logic [NUM_SRC-1:0]   fifo_full, fifo_empty, push, pop;

  logic [NUM_SRC-1:0]   grant;
  logic [CDB_WIDTH-1:0] lane_vld;
  logic [SRC_W-1:0]     lane_src [CDB_WIDTH];
  logic [SRC_W-1:0]     rr_q, rr_d;

  logic [CDB_WIDTH-1:0] out_vld_q;
  wb_entry_t            out_q [CDB_WIDTH];
  logic [31:0]          stall_q;
  logic                 any_stall;

  // ---------------------------------------------------------------- source FIFOs
  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    wb_entry_t in_entry;

    assign in_entry.value     = src_value_i[s*XLEN +: XLEN];
    assign in_entry.dest_prf  = src_dest_prf_i[s*PRF_W +: PRF_W];
    assign in_entry.rob_idx   = src_rob_idx_i[s*ROB_W +: ROB_W];
    assign in_entry.exception = src_exception_i[s];
    assign in_entry.mispred   = src_mispred_i[s];

    // Ready looks only at registered occupancy, never at a same-cycle pop.
    assign src_ready_o[s] = (fifo_cnt[s] < CNT_W'(FIFO_DEPTH));
    assign push[s]        = src_valid_i[s] & ~fifo_full[s] & ~flush_i;
    assign pop[s]         = grant[s] & ~flush_i;

    wb_fifo #(
      .WIDTH ($bits(wb_entry_t)),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk_i   (clock),
      .rst_i   (reset),
      .flush_i (flush_i),
      .push_i  (push[s]),
      .pop_i   (pop[s]),
      .data_i  (in_entry),
      .head_o  (head[s]),
      .count_o (fifo_cnt[s]),
      .full_o  (fifo_full[s]),
      .empty_o (fifo_empty[s])
    );
  end

  // ---------------------------------------------------------------- arbiter
  // Walk sources from rr_q upward (wrapping); k-th non-empty head takes lane k.
  always_comb begin
    int unsigned n_granted;
    int unsigned src;
    int unsigned last;
    grant     = '0;
    lane_vld  = '0;
    for (int unsigned k = 0; k < CDB_WIDTH; k++) begin
      lane_src[k] = '0;
    end
    n_granted = 0;
    last      = 32'(rr_q);
    src       = 0;
    for (int unsigned o = 0; o < NUM_SRC; o++) begin
      src = 32'(rr_q) + o;
      if (src >= NUM_SRC) src = src - NUM_SRC;
      if (!fifo_empty[src[SRC_W-1:0]] && (n_granted < CDB_WIDTH)) begin
        grant[src[SRC_W-1:0]]          = 1'b1;
        lane_vld[n_granted[LANE_W-1:0]] = 1'b1;
        lane_src[n_granted[LANE_W-1:0]] = src[SRC_W-1:0];
        last                            = src;
        n_granted                       = n_granted + 1;
      end
    end
    rr_d = rr_q;
    if (n_granted != 0) begin
      rr_d = ((last + 1) >= NUM_SRC) ? '0 : SRC_W'(last + 1);
    end
  end

  // Rotating pointer: follows the last grant, frozen across a flush.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_q <= '0;
    end else if (!flush_i) begin
      rr_q <= rr_d;
    end
  end

  // ---------------------------------------------------------------- output lanes
  // Load granted heads into packed lanes; unused lanes are fully zeroed.
  always_ff @(posedge clock) begin
    for (int unsigned k = 0; k < CDB_WIDTH; k++) begin
      if (reset || flush_i || !lane_vld[k]) begin
        out_q[k] <= '0;
      end else begin
        out_q[k] <= head[lane_src[k]];
      end
    end
    if (reset || flush_i) begin
      out_vld_q <= '0;
    end else begin
      out_vld_q <= lane_vld;
    end
  end

  for (genvar k = 0; k < CDB_WIDTH; k++) begin : g_lane
    assign prf_wr_en_o[k]                 = out_vld_q[k];
    assign prf_waddr_o[k*PRF_W +: PRF_W]  = out_q[k].dest_prf;
    assign prf_wdata_o[k*XLEN +: XLEN]    = out_q[k].value;
    assign wb_valid_o[k]                  = out_vld_q[k];
    assign wb_rob_idx_o[k*ROB_W +: ROB_W] = out_q[k].rob_idx;
    assign wb_exception_o[k]              = out_q[k].exception;
    assign wb_mispred_o[k]                = out_q[k].mispred;
    assign wb_value_o[k*XLEN +: XLEN]     = out_q[k].value;
    assign cdb_o[k].valid                 = out_vld_q[k];
    assign cdb_o[k].phys_tag              = out_q[k].dest_prf;
    assign cdb_o[k].dest_arch             = '0;
    assign cdb_o[k].value                 = out_q[k].value;
  end

  // ---------------------------------------------------------------- stall accounting
  assign any_stall      = |(src_valid_i & ~src_ready_o);
  assign stall_cycles_o = stall_q;

  // Saturating count of cycles where some producer was held off; runs during flush.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_q <= '0;
    end else if (any_stall && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_complete_arbiter.sv
// Self-checking bench for complete_arbiter: per-source queue reference model,
// a table of single-shot arbitration vectors, directed corner sequences and
// randomized traffic with flushes and resets.
module tb_complete_arbiter;
  import complete_arbiter_pkg::*;

  localparam int NS = 6, CW = 4, DEPTH = 2, XL = 32, PW = 7, RW = 6;

  logic                 clock = 1'b0;
  logic                 reset = 1'b0;
  logic                 flush_i = 1'b0;
  logic [NS-1:0]        src_valid_i, src_ready_o, src_exception_i, src_mispred_i;
  logic [NS*XL-1:0]     src_value_i;
  logic [NS*PW-1:0]     src_dest_prf_i;
  logic [NS*RW-1:0]     src_rob_idx_i;
  logic [CW-1:0]        prf_wr_en_o, wb_valid_o, wb_exception_o, wb_mispred_o;
  logic [CW*PW-1:0]     prf_waddr_o;
  logic [CW*XL-1:0]     prf_wdata_o, wb_value_o;
  logic [CW*RW-1:0]     wb_rob_idx_o;
  cdb_entry_t [CW-1:0]  cdb_o;
  logic [31:0]          stall_cycles_o;

  complete_arbiter #(
    .XLEN(XL), .PHYS_REGS(128), .ROB_DEPTH(64),
    .NUM_SRC(NS), .CDB_WIDTH(CW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clock(clock), .reset(reset), .flush_i(flush_i),
    .src_valid_i(src_valid_i), .src_ready_o(src_ready_o),
    .src_value_i(src_value_i), .src_dest_prf_i(src_dest_prf_i),
    .src_rob_idx_i(src_rob_idx_i), .src_exception_i(src_exception_i),
    .src_mispred_i(src_mispred_i),
    .prf_wr_en_o(prf_wr_en_o), .prf_waddr_o(prf_waddr_o), .prf_wdata_o(prf_wdata_o),
    .wb_valid_o(wb_valid_o), .wb_rob_idx_o(wb_rob_idx_o),
    .wb_exception_o(wb_exception_o), .wb_mispred_o(wb_mispred_o),
    .wb_value_o(wb_value_o), .cdb_o(cdb_o), .stall_cycles_o(stall_cycles_o)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [XL-1:0] value;
    logic [PW-1:0] prf;
    logic [RW-1:0] rob;
    logic          exc;
    logic          mis;
  } item_t;

  // Arbitration vector: sources pulsed once after reset, lane owners (F = empty).
  typedef struct packed {
    logic [NS-1:0]     mask;
    logic [3:0][3:0]   lsrc;
  } vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  item_t       mq [NS][$];
  int          m_rr;
  logic [31:0] m_stall;
  bit          m_known = 0;
  item_t       cur [NS];
  bit          cur_v [NS];
  bit          acc [NS];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  function automatic item_t mk(input int s, input int tag);
    item_t it;
    it.value = {tag[15:0], 8'hA5, s[7:0]};
    it.prf   = PW'(tag * 3 + s);
    it.rob   = RW'(tag + s);
    it.exc   = tag[0];
    it.mis   = s[0] ^ tag[1];
    return it;
  endfunction

  function automatic item_t rnd_item();
    item_t it;
    it.value = $urandom;
    it.prf   = PW'($urandom);
    it.rob   = RW'($urandom);
    it.exc   = 1'($urandom);
    it.mis   = 1'($urandom);
    return it;
  endfunction

  function automatic logic [255:0] act_lane(input int k);
    return 256'({prf_wr_en_o[k], prf_waddr_o[k*PW +: PW], prf_wdata_o[k*XL +: XL],
                 wb_valid_o[k], wb_rob_idx_o[k*RW +: RW], wb_exception_o[k], wb_mispred_o[k],
                 wb_value_o[k*XL +: XL], cdb_o[k].valid, cdb_o[k].phys_tag,
                 cdb_o[k].dest_arch, cdb_o[k].value});
  endfunction

  function automatic logic [255:0] exp_lane(input bit v, input item_t it);
    if (!v) return '0;
    return 256'({1'b1, it.prf, it.value, 1'b1, it.rob, it.exc, it.mis, it.value,
                 1'b1, it.prf, 5'd0, it.value});
  endfunction

  task automatic drive();
    for (int s = 0; s < NS; s++) begin
      src_valid_i[s]               = cur_v[s];
      src_value_i[s*XL +: XL]      = cur[s].value;
      src_dest_prf_i[s*PW +: PW]   = cur[s].prf;
      src_rob_idx_i[s*RW +: RW]    = cur[s].rob;
      src_exception_i[s]           = cur[s].exc;
      src_mispred_i[s]             = cur[s].mis;
    end
  endtask

  // One clock: check ready, advance the queue model across the edge, check outputs.
  task automatic step();
    logic [NS-1:0] rdy_e;
    bit            stalled;
    int            g [$];
    bit            out_v [CW];
    item_t         out_i [CW];
    stalled = 0;
    for (int s = 0; s < NS; s++) begin
      rdy_e[s] = (mq[s].size() < DEPTH);
      if (cur_v[s] && !rdy_e[s]) stalled = 1;
      acc[s] = 0;
    end
    if (m_known) chk("src_ready", 256'(src_ready_o), 256'(rdy_e));
    for (int k = 0; k < CW; k++) begin
      out_v[k] = 0;
      out_i[k] = '0;
    end
    if (reset) begin
      for (int s = 0; s < NS; s++) mq[s].delete();
      m_rr    = 0;
      m_stall = 0;
      m_known = 1;
    end else begin
      if (stalled && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      if (flush_i) begin
        for (int s = 0; s < NS; s++) mq[s].delete();
      end else begin
        for (int o = 0; o < NS; o++) begin
          int s = (m_rr + o) % NS;
          if (mq[s].size() > 0 && g.size() < CW) g.push_back(s);
        end
        for (int k = 0; k < g.size(); k++) begin
          out_v[k] = 1;
          out_i[k] = mq[g[k]].pop_front();
        end
        if (g.size() > 0) m_rr = (g[g.size()-1] + 1) % NS;
        for (int s = 0; s < NS; s++) begin
          if (cur_v[s] && rdy_e[s]) begin
            mq[s].push_back(cur[s]);
            acc[s] = 1;
          end
        end
      end
    end
    @(posedge clock);
    #1;
    if (m_known) begin
      for (int k = 0; k < CW; k++) chk($sformatf("lane%0d", k), act_lane(k), exp_lane(out_v[k], out_i[k]));
      chk("stall_cycles", 256'(stall_cycles_o), 256'(m_stall));
    end
  endtask

  task automatic advance();
    drive();
    step();
    for (int s = 0; s < NS; s++) if (acc[s]) cur_v[s] = 0;
  endtask

  task automatic do_reset();
    for (int s = 0; s < NS; s++) cur_v[s] = 0;
    flush_i = 0;
    reset   = 1;
    advance();
    reset   = 0;
  endtask

  function automatic logic [XL-1:0] lane_val(input int k);
    return wb_value_o[k*XL +: XL];
  endfunction

  initial begin
    vec_t   vecs [7];
    item_t  it;
    int     sent0, n0, vi;
    bit     saw_low;

    for (int s = 0; s < NS; s++) begin
      cur[s]   = '0;
      cur_v[s] = 0;
    end
    drive();
    #1;

    // Reset state
    do_reset();
    chk("rst_ready", 256'(src_ready_o), 256'(6'h3F));
    chk("rst_stall", 256'(stall_cycles_o), 256'd0);
    chk("rst_valid", 256'(wb_valid_o), 256'd0);
    advance();

    // Table of single-shot arbitration vectors, each from a fresh reset (rr = 0)
    vecs[0] = '{mask: 6'b000100, lsrc: 16'hFFF2};
    vecs[1] = '{mask: 6'b111111, lsrc: 16'h3210};
    vecs[2] = '{mask: 6'b101010, lsrc: 16'hF531};
    vecs[3] = '{mask: 6'b110001, lsrc: 16'hF540};
    vecs[4] = '{mask: 6'b000000, lsrc: 16'hFFFF};
    vecs[5] = '{mask: 6'b100000, lsrc: 16'hFFF5};
    vecs[6] = '{mask: 6'b011110, lsrc: 16'h4321};
    for (int i = 0; i < 7; i++) begin
      logic [CW-1:0] emask;
      do_reset();
      for (int s = 0; s < NS; s++) begin
        cur[s]   = mk(s, 500 + i);
        cur_v[s] = vecs[i].mask[s];
      end
      advance();
      chk("tbl_latency", 256'(wb_valid_o), 256'd0);
      advance();
      for (int k = 0; k < CW; k++) emask[k] = (vecs[i].lsrc[k] != 4'hF);
      chk($sformatf("tbl%0d_mask", i), 256'(wb_valid_o), 256'(emask));
      for (int k = 0; k < CW; k++) begin
        if (emask[k]) chk($sformatf("tbl%0d_lane%0d", i, k), 256'(lane_val(k)),
                          256'(mk(int'(vecs[i].lsrc[k]), 500 + i).value));
      end
    end

    // Single result from src 2
    do_reset();
    it.value = 32'hDEAD_BEEF; it.prf = 7'd17; it.rob = 6'd5; it.exc = 0; it.mis = 0;
    cur[2] = it; cur_v[2] = 1;
    advance();
    chk("single_no_bypass", 256'(wb_valid_o), 256'd0);
    advance();
    chk("single_valid", 256'(wb_valid_o), 256'(4'b0001));
    chk("single_value", 256'(lane_val(0)), 256'(32'hDEAD_BEEF));
    chk("single_prf", 256'(prf_waddr_o[PW-1:0]), 256'd17);
    chk("single_rob", 256'(wb_rob_idx_o[RW-1:0]), 256'd5);

    // Oversubscription: six results, four lanes
    do_reset();
    for (int s = 0; s < NS; s++) begin cur[s] = mk(s, 10); cur_v[s] = 1; end
    advance();
    advance();
    chk("over_c1_mask", 256'(wb_valid_o), 256'(4'hF));
    for (int k = 0; k < CW; k++) chk("over_c1_src", 256'(lane_val(k)), 256'(mk(k, 10).value));
    advance();
    chk("over_c2_mask", 256'(wb_valid_o), 256'(4'b0011));
    chk("over_c2_l0", 256'(lane_val(0)), 256'(mk(4, 10).value));
    chk("over_c2_l1", 256'(lane_val(1)), 256'(mk(5, 10).value));
    cur[5] = mk(5, 11); cur_v[5] = 1;
    cur[0] = mk(0, 11); cur_v[0] = 1;
    advance();
    advance();
    chk("over_rr_wrap_l0", 256'(lane_val(0)), 256'(mk(0, 11).value));
    chk("over_rr_wrap_l1", 256'(lane_val(1)), 256'(mk(5, 11).value));

    // Backpressure: src 0 offers 4 results while src 1..5 stay busy
    do_reset();
    sent0 = 0; n0 = 0; saw_low = 0;
    for (int c = 0; c < 24; c++) begin
      if (!cur_v[0] && sent0 < 4) begin cur[0] = mk(0, 100 + sent0); cur_v[0] = 1; sent0++; end
      for (int s = 1; s < NS; s++) if (!cur_v[s] && c < 14) begin cur[s] = mk(s, 200 + c); cur_v[s] = 1; end
      advance();
      if (!src_ready_o[0]) saw_low = 1;
      for (int k = 0; k < CW; k++) begin
        logic [XL-1:0] v;
        v = lane_val(k);
        if (wb_valid_o[k] && v[15:0] == 16'hA500) begin
          chk("bp_order", 256'(v[31:16]), 256'(100 + n0));
          n0++;
        end
      end
    end
    chk("bp_ready_dropped", 256'(saw_low), 256'd1);
    chk("bp_all_src0_out", 256'(n0), 256'd4);
    chk("bp_stall_nonzero", 256'(stall_cycles_o != 0), 256'd1);

    // Flush with buffered entries and valid outputs
    do_reset();
    for (int s = 0; s < NS; s++) begin cur[s] = mk(s, 300); cur_v[s] = 1; end
    advance();
    for (int s = 0; s < 3; s++) begin cur[s] = mk(s, 301); cur_v[s] = 1; end
    advance();
    chk("flush_pre_valid", 256'(wb_valid_o), 256'(4'hF));
    flush_i = 1;
    cur[3] = mk(3, 302); cur_v[3] = 1;
    advance();
    flush_i = 0;
    cur_v[3] = 0;
    chk("flush_out_clear", 256'(wb_valid_o), 256'd0);
    chk("flush_ready", 256'(src_ready_o), 256'(6'h3F));
    advance();
    chk("flush_fifos_empty", 256'(wb_valid_o), 256'd0);
    for (int s = 0; s < NS; s++) begin cur[s] = mk(s, 303); cur_v[s] = 1; end
    advance();
    advance();
    chk("flush_rr_held_l0", 256'(lane_val(0)), 256'(mk(4, 303).value));
    chk("flush_rr_held_l1", 256'(lane_val(1)), 256'(mk(5, 303).value));

    // Reset while FIFOs are full, then a push in the first post-reset cycle
    do_reset();
    for (int c = 0; c < 6; c++) begin
      for (int s = 0; s < NS; s++) if (!cur_v[s]) begin cur[s] = mk(s, 400 + c); cur_v[s] = 1; end
      advance();
    end
    reset = 1;
    advance();
    reset = 0;
    for (int s = 0; s < NS; s++) cur_v[s] = 0;
    chk("rst_mid_valid", 256'(wb_valid_o), 256'd0);
    chk("rst_mid_ready", 256'(src_ready_o), 256'(6'h3F));
    chk("rst_mid_stall", 256'(stall_cycles_o), 256'd0);
    cur[3] = mk(3, 450); cur_v[3] = 1;
    advance();
    chk("rst_push_latency", 256'(wb_valid_o), 256'd0);
    advance();
    chk("rst_push_mask", 256'(wb_valid_o), 256'(4'b0001));
    chk("rst_push_value", 256'(lane_val(0)), 256'(mk(3, 450).value));

    // Randomized traffic with occasional flush and reset
    for (int c = 0; c < 3000; c++) begin
      int pct;
      vi  = (c / 500) % 3;
      pct = (vi == 0) ? 30 : ((vi == 1) ? 70 : 95);
      for (int s = 0; s < NS; s++) begin
        if (!cur_v[s] && $urandom_range(0, 99) < pct) begin cur[s] = rnd_item(); cur_v[s] = 1; end
      end
      flush_i = ($urandom_range(0, 49) == 0);
      reset   = ($urandom_range(0, 299) == 0);
      advance();
    end
    flush_i = 0;
    reset   = 0;
    for (int s = 0; s < NS; s++) cur_v[s] = 0;
    for (int c = 0; c < 6; c++) advance();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
